// File: rtl/raymarch_scheduler.sv
// Raymarch scheduler: dispatches raster pixels to NUM_CORES cores and
// round-robins their results into one frame-buffer write port.
// Ports: clk_in/rst_in/enable_in, core_start_out/core_x_out/core_y_out/
// timer_out to cores, core_done_in/core_color_in/core_ox_in/core_oy_in
// from cores, fb_we_out/fb_addr_out/fb_data_out/frame_done_out to memory.
module raymarch_scheduler #(
  parameter int WIDTH = 1280,
  parameter int HEIGHT = 720,
  parameter int NUM_CORES = 3,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int AW = $clog2(WIDTH*HEIGHT)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    enable_in,
  output logic [NUM_CORES-1:0]    core_start_out,
  output logic [XW-1:0]           core_x_out,
  output logic [YW-1:0]           core_y_out,
  output logic [31:0]             timer_out,
  input  logic [NUM_CORES-1:0]    core_done_in,
  input  logic [24*NUM_CORES-1:0] core_color_in,
  input  logic [XW*NUM_CORES-1:0] core_ox_in,
  input  logic [YW*NUM_CORES-1:0] core_oy_in,
  output logic                    fb_we_out,
  output logic [AW-1:0]           fb_addr_out,
  output logic [23:0]             fb_data_out,
  output logic                    frame_done_out
);

  localparam int N = NUM_CORES;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int LASTA = WIDTH*HEIGHT-1;

  logic [N-1:0]  r_busy;
  logic [N-1:0]  r_sv;
  logic [XW-1:0] r_sx [N];
  logic [YW-1:0] r_sy [N];
  logic [23:0]   r_sc [N];
  logic [XW-1:0] r_px;
  logic [YW-1:0] r_py;
  logic [PW-1:0] r_ptr;

  logic [N-1:0]  w_avail;
  logic [N-1:0]  w_start;
  logic          w_disp;
  logic          w_grant;
  logic [PW-1:0] w_win;
  logic [AW-1:0] w_waddr;

  function automatic logic [PW-1:0] rr_idx(
    input logic [PW-1:0] p,
    input int k
  );
    int j;
    j = int'(p) + k;
    if (j >= N) j = j - N;
    return PW'(j);
  endfunction

  // lowest available core: isolate least significant set bit
  always_comb begin
    w_avail = ~r_busy & ~r_sv;
    w_start = '0;
    if (enable_in)
      w_start = w_avail & (~w_avail + N'(1));
    w_disp = |w_start;
  end

  // scan from the pointer; the k=0 hit is assigned last and wins
  always_comb begin
    w_grant = 1'b0;
    w_win = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (r_sv[rr_idx(r_ptr, k)]) begin
        w_grant = 1'b1;
        w_win = rr_idx(r_ptr, k);
      end
    end
    w_waddr = AW'(64'(r_sx[w_win])
      + 64'(WIDTH) * 64'(r_sy[w_win]));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      core_start_out <= '0;
      core_x_out <= '0;
      core_y_out <= '0;
      timer_out <= '0;
      fb_we_out <= 1'b0;
      fb_addr_out <= '0;
      fb_data_out <= '0;
      frame_done_out <= 1'b0;
      r_busy <= '0;
      r_sv <= '0;
      r_px <= '0;
      r_py <= '0;
      r_ptr <= '0;
      for (int i = 0; i < N; i++) begin
        r_sx[i] <= '0;
        r_sy[i] <= '0;
        r_sc[i] <= '0;
      end
    end else begin
      core_start_out <= w_start;
      if (w_disp) begin
        core_x_out <= r_px;
        core_y_out <= r_py;
        if (int'(r_px) == WIDTH-1) begin
          r_px <= '0;
          if (int'(r_py) == HEIGHT-1) begin
            r_py <= '0;
            timer_out <= timer_out + 32'd1;
          end else begin
            r_py <= r_py + YW'(1);
          end
        end else begin
          r_px <= r_px + XW'(1);
        end
      end
      fb_we_out <= w_grant;
      frame_done_out <= w_grant &&
        (int'(w_waddr) == LASTA);
      if (w_grant) begin
        fb_addr_out <= w_waddr;
        fb_data_out <= r_sc[w_win];
        r_ptr <= (int'(w_win) == N-1) ?
          '0 : w_win + PW'(1);
      end
      // start, capture and grant are mutually
      // exclusive per core: avail / busy / valid
      for (int i = 0; i < N; i++) begin
        if (w_start[i]) begin
          r_busy[i] <= 1'b1;
        end else if (core_done_in[i] && r_busy[i]) begin
          r_busy[i] <= 1'b0;
          r_sv[i] <= 1'b1;
          r_sx[i] <= core_ox_in[XW*i +: XW];
          r_sy[i] <= core_oy_in[YW*i +: YW];
          r_sc[i] <= core_color_in[24*i +: 24];
        end else if (w_grant && w_win == PW'(i)) begin
          r_sv[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_raymarch_scheduler.sv
// Bench for raymarch_scheduler at 4x2 pixels, 3 cores:
// directed vectors, corner sequences and fake-core random traffic.
module tb_raymarch_scheduler;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = 3;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int AW = $clog2(W*H);

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [N-1:0] start;
  logic [N-1:0] done;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [31:0] timer;
  logic [24*N-1:0] color;
  logic [XW*N-1:0] ox;
  logic [YW*N-1:0] oy;
  logic we;
  logic [AW-1:0] addr;
  logic [23:0] data;
  logic fd;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  raymarch_scheduler #(
    .WIDTH(W), .HEIGHT(H), .NUM_CORES(N)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .enable_in(en),
    .core_start_out(start),
    .core_x_out(cx),
    .core_y_out(cy),
    .timer_out(timer),
    .core_done_in(done),
    .core_color_in(color),
    .core_ox_in(ox),
    .core_oy_in(oy),
    .fb_we_out(we),
    .fb_addr_out(addr),
    .fb_data_out(data),
    .frame_done_out(fd)
  );

  typedef struct {
    int core;
    int x;
    int y;
    logic [23:0] c;
    int ea;
    bit efd;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_done(input int c, input int x,
                          input int y,
                          input logic [23:0] col);
    done[c] = 1'b1;
    ox[XW*c +: XW] = XW'(x);
    oy[YW*c +: YW] = YW'(y);
    color[24*c +: 24] = col;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    done = '0;
    tick();
    tick();
    check("rst_ctl", {start, cx, cy, we, addr, fd}, 0);
    check("rst_timer", timer, 0);
    check("rst_data", data, 0);
    rst = 1'b0;
  endtask

  // reset, then three starts on consecutive cycles
  task automatic start3();
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("s3_start", start, 1 << k);
      check("s3_xy", {cx, cy}, {XW'(k), YW'(0)});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("s3_idle", {start, we}, 0);
    end
  endtask

  task automatic run_fake(input int ncyc, input int lat,
                          input bit rnd, input int maxd);
    bit own[N];
    bit res[N];
    int oa[N];
    int due[N];
    int fat[N];
    bit pend[W*H];
    logic [23:0] ecol[W*H];
    int wcnt[W*H];
    int nxt, disp, etmr, fdc, nwr, lo, left;
    logic [N-1:0] es;
    logic [23:0] col;
    bit enp;
    for (int i = 0; i < N; i++) begin
      own[i] = 0; res[i] = 0; fat[i] = -10;
      oa[i] = 0; due[i] = 0;
    end
    for (int a = 0; a < W*H; a++) begin
      pend[a] = 0; wcnt[a] = 0; ecol[a] = '0;
    end
    nxt = 0; disp = 0; etmr = 0; fdc = 0; nwr = 0;
    do_reset();
    en = 1'b1;
    enp = 1'b1;
    for (int s = 1; s <= ncyc; s++) begin
      tick();
      es = '0;
      lo = -1;
      if (enp) begin
        for (int i = N-1; i >= 0; i--)
          if (!own[i] && fat[i] <= s-1) lo = i;
        if (lo >= 0) es[lo] = 1'b1;
      end
      check("start", start, es);
      if (es != 0 && start == es) begin
        check("start_x", cx, nxt % W);
        check("start_y", cy, nxt / W);
        own[lo] = 1;
        res[lo] = 0;
        oa[lo] = nxt;
        due[lo] = s + (rnd ? int'($urandom_range(1, 6)) : lat);
        if (nxt == W*H-1) etmr++;
        nxt = (nxt + 1) % (W*H);
        disp++;
      end
      check("timer", timer, etmr);
      if (we) begin
        nwr++;
        check("wr_pending", pend[addr], 1);
        if (pend[addr]) check("wr_data", data, ecol[addr]);
        check("frame_done", fd, int'(addr) == W*H-1);
        if (fd) fdc++;
        pend[addr] = 0;
        wcnt[addr]++;
        for (int i = 0; i < N; i++)
          if (own[i] && res[i] && oa[i] == int'(addr)) begin
            own[i] = 0;
            fat[i] = s;
          end
      end else begin
        check("fd_idle", fd, 0);
      end
      done = '0;
      for (int i = 0; i < N; i++) begin
        if (own[i] && !res[i] && due[i] <= s) begin
          col = 24'($urandom);
          set_done(i, oa[i] % W, oa[i] / W, col);
          res[i] = 1;
          pend[oa[i]] = 1;
          ecol[oa[i]] = col;
        end else if (rnd && (!own[i] || res[i]) &&
                     $urandom_range(0, 7) == 0) begin
          set_done(i, $urandom_range(0, W-1),
                   $urandom_range(0, H-1), 24'($urandom));
        end
      end
      en = (disp < maxd) && (!rnd || $urandom_range(0, 3) != 0);
      enp = en;
    end
    en = 1'b0;
    done = '0;
    left = 0;
    for (int a = 0; a < W*H; a++) if (pend[a]) left++;
    check("drain_writes", nwr, disp);
    check("dispatched", disp, maxd);
    check("left_pending", left, 0);
    check("frames", fdc, maxd / (W*H));
    check("timer_end", timer, maxd / (W*H));
    if (!rnd)
      for (int a = 0; a < W*H; a++)
        check("addr_count", wcnt[a], maxd / (W*H));
  endtask

  initial begin
    int nw;
    int ns;
    rst = 1'b1;
    en = 1'b0;
    done = '0;
    ox = '0;
    oy = '0;
    color = '0;

    start3();

    tbl[0] = '{1, 1, 0, 24'hABCDEF, 1, 1'b0};
    tbl[1] = '{0, 3, 1, 24'h123456, 7, 1'b1};
    tbl[2] = '{2, 0, 1, 24'h00FF00, 4, 1'b0};
    tbl[3] = '{1, 2, 1, 24'hFFFFFF, 6, 1'b0};
    foreach (tbl[i]) begin
      start3();
      set_done(tbl[i].core, tbl[i].x, tbl[i].y, tbl[i].c);
      tick();
      done = '0;
      tick();
      check("v_we", we, 1);
      check("v_addr", addr, tbl[i].ea);
      check("v_data", data, tbl[i].c);
      check("v_fd", fd, tbl[i].efd);
      tick();
      check("v_we_off", we, 0);
      check("v_restart", start, 1 << tbl[i].core);
      check("v_rxy", {cx, cy}, {XW'(3), YW'(0)});
    end

    // simultaneous dones, then round-robin from ptr=2
    start3();
    en = 1'b0;
    set_done(0, 0, 0, 24'h0000A0);
    set_done(1, 1, 0, 24'h0000A1);
    set_done(2, 2, 0, 24'h0000A2);
    tick();
    done = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rr_we", we, 1);
      check("rr_addr", addr, k);
      check("rr_data", data, 24'hA0 + k);
    end
    tick();
    check("rr_we_off", we, 0);
    en = 1'b1;
    tick();
    check("rr_s0", {start, cx, cy}, {3'b001, 2'd3, 1'd0});
    tick();
    check("rr_s1", {start, cx, cy}, {3'b010, 2'd0, 1'd1});
    tick();
    check("rr_s2", {start, cx, cy}, {3'b100, 2'd1, 1'd1});
    en = 1'b0;
    set_done(1, 0, 1, 24'h0000B1);
    tick();
    done = '0;
    tick();
    check("rr2_addr", {we, addr}, {1'b1, 3'd4});
    set_done(0, 3, 0, 24'h0000B0);
    set_done(2, 1, 1, 24'h0000B2);
    tick();
    done = '0;
    tick();
    check("rr3_first", {we, addr}, {1'b1, 3'd5});
    check("rr3_data", data, 24'hB2);
    tick();
    check("rr3_second", {we, addr}, {1'b1, 3'd3});
    tick();
    check("rr3_off", we, 0);

    // enable drop after four dispatches
    start3();
    set_done(0, 0, 0, 24'h111111);
    tick();
    done = '0;
    tick();
    check("en_w0", {we, addr}, {1'b1, 3'd0});
    tick();
    check("en_s4", {start, cx, cy}, {3'b001, 2'd3, 1'd0});
    en = 1'b0;
    set_done(0, 3, 0, 24'h222222);
    set_done(1, 1, 0, 24'h333333);
    set_done(2, 2, 0, 24'h444444);
    tick();
    done = '0;
    nw = 1;
    ns = 0;
    repeat (8) begin
      tick();
      if (we) nw++;
      if (start != 0) ns++;
    end
    check("en_writes", nw, 4);
    check("en_nostart", ns, 0);
    en = 1'b1;
    tick();
    check("en_resume", {start, cx, cy}, {3'b001, 2'd0, 1'd1});

    // done on idle core is ignored
    do_reset();
    set_done(2, 2, 0, 24'h555555);
    tick();
    done = '0;
    nw = 0;
    repeat (5) begin
      tick();
      if (we || start != 0) nw++;
    end
    check("idle_done", nw, 0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_starts", start, 1 << k);
    end

    // reset with all slots full
    start3();
    en = 1'b0;
    set_done(0, 0, 0, 24'h666666);
    set_done(1, 1, 0, 24'h777777);
    set_done(2, 2, 0, 24'h888888);
    tick();
    done = '0;
    rst = 1'b1;
    tick();
    check("mrst_we", {we, start}, 0);
    tick();
    rst = 1'b0;
    nw = 0;
    repeat (4) begin
      tick();
      if (we) nw++;
    end
    check("mrst_nowrite", nw, 0);
    check("mrst_timer", timer, 0);
    en = 1'b1;
    tick();
    check("mrst_start", {start, cx, cy}, {3'b001, 2'd0, 1'd0});

    run_fake(150, 5, 1'b0, 16);
    run_fake(3000, 0, 1'b1, 400);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
